voice_mix_scheduler: RTL and testbench
======================================

VOICE_MIX_SCHEDULER -- requirements
Module: voice_mix_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning signed audio sample width.
REQ-002 SHALL have parameter ENVELOPE_WIDTH, default 32, meaning unsigned Q0.31 envelope width (0x7FFFFFFF = ~1.0).
REQ-003 SHALL have parameter NUM_VOICES, default 8, meaning number of voices sharing the one multiplier; range 2..32.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port sample_tick, input, 1, frame start request, one-cycle pulse.
REQ-007 SHALL have port voice_audio, input, NUM_VOICES*DATA_WIDTH, flattened signed samples; voice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port voice_env, input, NUM_VOICES*ENVELOPE_WIDTH, flattened envelopes, packed the same way.
REQ-009 SHALL have port voice_active, input, NUM_VOICES, per-voice enable.
REQ-010 SHALL have port mix_out, output, DATA_WIDTH, signed mixed sample, registered.
REQ-011 SHALL have port mix_valid, output, 1, one-cycle pulse qualifying mix_out.
REQ-012 SHALL have port busy, output, 1, high whenever FSM is not IDLE.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when sample_tick arrives while busy.

Function
REQ-014 SHALL implement FSM states IDLE, MAC, DRAIN, OUTPUT.
REQ-015 In IDLE, sample_tick SHALL snapshot voice_audio, voice_env and voice_active into registers, clear accumulator, set voice index to 0, and enter MAC.
REQ-016 In MAC, one voice SHALL be issued per cycle in ascending index order; inputs changing after the snapshot SHALL not affect the frame.
REQ-017 The shared multiplier SHALL compute signed audio times envelope (envelope zero-extended to signed), keep product bits [62:31], and register the result (1-cycle latency).
REQ-018 Inactive voices SHALL contribute 0 but SHALL still consume their issue cycle (fixed frame timing).
REQ-019 Accumulator SHALL be signed, DATA_WIDTH+clog2(NUM_VOICES)+1 bits, and SHALL never overflow internally.
REQ-020 After issuing index NUM_VOICES-1, the FSM SHALL enter DRAIN for exactly 1 cycle to accumulate the last product, then enter OUTPUT.
REQ-021 OUTPUT SHALL load mix_out, pulse mix_valid for 1 cycle, and return to IDLE; mix_out SHALL hold until the next OUTPUT.
REQ-022 Latency SHALL be fixed: sample_tick sampled at edge T gives mix_valid high in cycle T+NUM_VOICES+2.
REQ-023 sample_tick while busy SHALL be ignored for frame control and SHALL pulse overrun in the following cycle.
REQ-024 sample_tick in the same cycle as OUTPUT SHALL be treated as overrun; back-to-back frames require the tick in IDLE.

Reset
REQ-025 On rst_n low, FSM SHALL go to IDLE, and mix_out, mix_valid, busy, overrun, accumulator and index SHALL be 0 immediately, regardless of clk.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no mix_valid; the first tick after release SHALL start a clean frame.

Configuration
REQ-027 Macro MIX_SATURATE_EN defined: at OUTPUT, accumulator SHALL clamp to [0x80000000, 0x7FFFFFFF] (DATA_WIDTH=32).
REQ-028 Macro MIX_SATURATE_EN undefined: mix_out SHALL be the low DATA_WIDTH bits of the accumulator (two's-complement wrap).

Verification
REQ-029 One voice active, audio 0x40000000, env 0x40000000, rest inactive -> mix_out 0x20000000, mix_valid at T+10 (NUM_VOICES=8).
REQ-030 All 8 voices audio 0x40000000, env 0x7FFFFFFF -> each product 0x3FFFFFFF; MIX_SATURATE_EN gives 0x7FFFFFFF, otherwise 0xFFFFFFF8.
REQ-031 All 8 voices audio 0x80000000, env 0x7FFFFFFF -> each product 0x80000001; MIX_SATURATE_EN gives 0x80000000.
REQ-032 Second sample_tick 3 cycles after the first -> overrun pulses once, exactly one mix_valid, and the result is unchanged.
REQ-033 Voice inputs changed during MAC -> mix_out reflects the snapshot values only.
REQ-034 rst_n low at cycle T+4 of a frame -> all outputs 0 asynchronously, no mix_valid; the next tick produces a correct result.

Source files
------------

// File: rtl/voice_mix_scheduler.sv
// Time-multiplexed voice mixer: a single registered multiplier scales one voice per cycle into a wide accumulator.
// Define MIX_SATURATE_EN to clamp the mixed result to the signed DATA_WIDTH range instead of wrapping.
module voice_mix_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ENVELOPE_WIDTH = 32,
  parameter int NUM_VOICES     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sample_tick,
  input  logic [NUM_VOICES*DATA_WIDTH-1:0]     voice_audio,
  input  logic [NUM_VOICES*ENVELOPE_WIDTH-1:0] voice_env,
  input  logic [NUM_VOICES-1:0]                voice_active,
  output logic signed [DATA_WIDTH-1:0]         mix_out,
  output logic                                 mix_valid,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = DATA_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = DATA_WIDTH + ENVELOPE_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUTPUT} state_t;

  state_t state, state_next;

  logic [NUM_VOICES*DATA_WIDTH-1:0]     audio_snap;
  logic [NUM_VOICES*ENVELOPE_WIDTH-1:0] env_snap;
  logic [NUM_VOICES-1:0]                active_snap;

  logic [IDX_W-1:0]             idx;
  logic                         last_issue;
  logic signed [DATA_WIDTH-1:0] prod, prod_next;
  logic                         prod_vld;
  logic signed [ACC_W-1:0]      acc, prod_ext;
  logic signed [DATA_WIDTH-1:0] mix_next;

  logic signed [DATA_WIDTH-1:0]   audio_sel;
  logic [ENVELOPE_WIDTH-1:0]      env_sel;
  logic                           active_sel;
  logic signed [PROD_W-1:0]       audio_ext, env_ext, prod_full;
  logic                           prod_unused;
  int                             audio_base, env_base;

  assign busy       = (state != IDLE);
  assign last_issue = (idx == IDX_W'(NUM_VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = MAC;
      MAC:     if (last_issue)  state_next = DRAIN;
      DRAIN:   state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the snapshot is pure data qualified by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_tick) begin
      audio_snap  <= voice_audio;
      env_snap    <= voice_env;
      active_snap <= voice_active;
    end
  end

  // Envelope is unsigned Q0.x: zero-extend before the signed multiply, keep the Q-aligned window.
  always_comb begin
    audio_base  = int'(idx) * DATA_WIDTH;
    env_base    = int'(idx) * ENVELOPE_WIDTH;
    audio_sel   = audio_snap[audio_base +: DATA_WIDTH];
    env_sel     = env_snap[env_base +: ENVELOPE_WIDTH];
    active_sel  = active_snap[idx];
    audio_ext   = {{(PROD_W-DATA_WIDTH){audio_sel[DATA_WIDTH-1]}}, audio_sel};
    env_ext     = {{(PROD_W-ENVELOPE_WIDTH){1'b0}}, env_sel};
    prod_full   = audio_ext * env_ext;
    prod_next   = active_sel ? prod_full[ENVELOPE_WIDTH-1 +: DATA_WIDTH] : '0;
    prod_unused = ^{prod_full[PROD_W-1 -: 2], prod_full[ENVELOPE_WIDTH-2:0]};
  end

  assign prod_ext = {{(ACC_W-DATA_WIDTH){prod[DATA_WIDTH-1]}}, prod};

`ifdef MIX_SATURATE_EN
  always_comb begin
    mix_next = acc[DATA_WIDTH-1:0];
    if (!((&acc[ACC_W-1:DATA_WIDTH-1]) || !(|acc[ACC_W-1:DATA_WIDTH-1])))
      mix_next = acc[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  always_comb mix_next = acc[DATA_WIDTH-1:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc      <= '0;
            idx      <= '0;
            prod_vld <= 1'b0;
          end
        end
        MAC: begin
          prod     <= prod_next;
          prod_vld <= 1'b1;
          if (prod_vld) acc <= acc + prod_ext;
          idx <= last_issue ? '0 : idx + IDX_W'(1);
        end
        DRAIN: begin
          acc      <= acc + prod_ext;
          prod_vld <= 1'b0;
        end
        OUTPUT: begin
          mix_out   <= mix_next;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Scoreboard bench for voice_mix_scheduler: driver pushes expected mix results and arrival edges, monitor pops on mix_valid.
module tb_voice_mix_scheduler;

  localparam int DW = 32;
  localparam int EW = 32;
  localparam int NV = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sample_tick = 1'b0;
  logic [NV*DW-1:0]    voice_audio = '0;
  logic [NV*EW-1:0]    voice_env = '0;
  logic [NV-1:0]       voice_active = '0;
  logic signed [DW-1:0] mix_out;
  logic                mix_valid;
  logic                busy;
  logic                overrun;

  voice_mix_scheduler #(.DATA_WIDTH(DW), .ENVELOPE_WIDTH(EW), .NUM_VOICES(NV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .voice_audio  (voice_audio),
    .voice_env    (voice_env),
    .voice_active (voice_active),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int edge_count = 0;
  always @(posedge clk) edge_count++;

  typedef struct {
    logic [DW-1:0] value;
    int            edge_no;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int valid_seen = 0;
  int overrun_seen = 0;

`ifdef MIX_SATURATE_EN
  localparam logic [DW-1:0] EXP_POS_FULL = 32'h7FFFFFFF;
  localparam logic [DW-1:0] EXP_NEG_FULL = 32'h80000000;
`else
  localparam logic [DW-1:0] EXP_POS_FULL = 32'hFFFFFFF8;
  localparam logic [DW-1:0] EXP_NEG_FULL = 32'h00000008;
`endif

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every mix_valid must match the oldest expected frame in value and arrival edge.
  always @(negedge clk) begin
    if (overrun === 1'b1) overrun_seen++;
    if (mix_valid === 1'b1) begin
      valid_seen++;
      if (sb_q.size() == 0) begin
        check("spurious_valid", DW'(mix_valid), '0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mix_out", mix_out, e.value);
        check("latency_edge", DW'(edge_count), DW'(e.edge_no));
      end
    end
  end

  task automatic set_voice(input int i, input logic [DW-1:0] a, input logic [EW-1:0] e, input logic act);
    voice_audio[i*DW +: DW] = a;
    voice_env[i*EW +: EW]   = e;
    voice_active[i]         = act;
  endtask

  // Inactive voices carry large data so a leak into the mix is visible.
  task automatic clear_voices();
    for (int i = 0; i < NV; i++) set_voice(i, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
  endtask

  task automatic load_one();
    clear_voices();
    set_voice(3, 32'h40000000, 32'h40000000, 1'b1);
  endtask

  task automatic load_all(input logic [DW-1:0] a, input logic [EW-1:0] e);
    for (int i = 0; i < NV; i++) set_voice(i, a, e, 1'b1);
  endtask

  // 0x08000000 - 0x08000000 + 1 - 2 (floor of +1.5 and -1.5) = -1.
  task automatic load_mixed();
    clear_voices();
    set_voice(0, 32'h10000000, 32'h40000000, 1'b1);
    set_voice(1, 32'hF0000000, 32'h40000000, 1'b1);
    set_voice(5, 32'h00000003, 32'h40000000, 1'b1);
    set_voice(6, 32'h7FFFFFFF, 32'h00000000, 1'b1);
    set_voice(7, 32'hFFFFFFFD, 32'h40000000, 1'b1);
  endtask

  // Called at a negedge; tick is sampled at the next posedge T, result expected after edge T+NV+2.
  task automatic tick_frame(input logic [DW-1:0] exp_val);
    exp_t e;
    e.value   = exp_val;
    e.edge_no = edge_count + 1 + NV + 2;
    sb_q.push_back(e);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_raw();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", DW'(n >= 200), '0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o0;
    int v0;
    clear_voices();
    #12;
    check("reset_mix_out", mix_out, '0);
    check("reset_mix_valid", DW'(mix_valid), '0);
    check("reset_busy", DW'(busy), '0);
    check("reset_overrun", DW'(overrun), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single active voice: 0.5 * 0.5.
    load_one();
    tick_frame(32'h20000000);
    check("busy_in_frame", DW'(busy), 32'd1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("mix_out_hold", mix_out, 32'h20000000);

    load_all(32'h40000000, 32'h7FFFFFFF);
    tick_frame(EXP_POS_FULL);
    wait_drain();

    load_all(32'h80000000, 32'h7FFFFFFF);
    tick_frame(EXP_NEG_FULL);
    wait_drain();

    load_mixed();
    tick_frame(32'hFFFFFFFF);
    wait_drain();

    // Inputs change after the snapshot edge; the frame must not see them.
    load_one();
    tick_frame(32'h20000000);
    load_all(32'h7FFFFFFF, 32'h7FFFFFFF);
    @(negedge clk);
    load_mixed();
    wait_drain();

    // Second tick three edges after the first.
    load_one();
    o0 = overrun_seen;
    v0 = valid_seen;
    tick_frame(32'h20000000);
    repeat (2) @(negedge clk);
    pulse_raw();
    check("overrun_pulse", DW'(overrun), 32'd1);
    @(negedge clk);
    check("overrun_one_cycle", DW'(overrun), '0);
    wait_drain();
    check("overrun_count", DW'(overrun_seen - o0), 32'd1);
    check("valid_count", DW'(valid_seen - v0), 32'd1);

    // Tick during OUTPUT is an overrun; the tick right after in IDLE starts the next frame.
    o0 = overrun_seen;
    v0 = valid_seen;
    tick_frame(32'h20000000);
    repeat (NV + 1) @(negedge clk);
    pulse_raw();
    check("output_tick_overrun", DW'(overrun), 32'd1);
    check("output_tick_idle", DW'(busy), '0);
    load_mixed();
    tick_frame(32'hFFFFFFFF);
    check("back_to_back_busy", DW'(busy), 32'd1);
    wait_drain();
    check("output_overrun_count", DW'(overrun_seen - o0), 32'd1);
    check("back_to_back_valid_count", DW'(valid_seen - v0), 32'd2);

    // Asynchronous reset mid-frame aborts it with no mix_valid.
    load_one();
    pulse_raw();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mix_out", mix_out, '0);
    check("abort_mix_valid", DW'(mix_valid), '0);
    check("abort_busy", DW'(busy), '0);
    check("abort_overrun", DW'(overrun), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NV + 4) @(negedge clk);
    load_all(32'h40000000, 32'h7FFFFFFF);
    tick_frame(EXP_POS_FULL);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
